// File: rtl/seq_add_sub_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder/subtractor.
package seq_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int num_chunks(int width, int chunk);
        return width / chunk;
    endfunction

    // Counter needs at least one bit even when a single chunk covers the word.
    function automatic int cnt_width(int width, int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit config_ok(int width, int chunk);
        return (width >= 2) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/seq_add_sub_chunk_adder.sv
// CHUNK-bit ripple-carry adder; also exposes the carry into its top bit for overflow detection.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle two's-complement adder/subtractor: one CHUNK-bit slice per clock, LSB first,
// with valid/ready handshakes on both sides and carry/overflow/zero/negative flags.
module seq_add_sub
    import seq_add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
    localparam int CW     = cnt_width(WIDTH, CHUNK);
    localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> CHUNK;

    generate
        if (!config_ok(WIDTH, CHUNK)) begin : g_bad_cfg
            $error("seq_add_sub: WIDTH must be >= 2 and an exact multiple of CHUNK");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q, b_q, result_q;
    logic [CHUNK-1:0]  x_chunk, y_chunk, sum;
    logic              cout, c_msb;
    logic              accept, last;

    assign last   = (cnt_q == CW'(NCHUNK - 1));
    assign accept = in_valid & in_ready;
    assign result = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A DONE state with out_ready frees the slot, so a new bundle can be taken on that same edge.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = !rst && out_ready;
                if (out_ready) state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_chunk = '0;
        y_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                x_chunk = a_q[i*CHUNK +: CHUNK];
                y_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .x     (x_chunk),
        .y     (y_chunk),
        .cin   (carry_q),
        .sum   (sum),
        .cout  (cout),
        .c_msb (c_msb)
    );

    // Subtraction is a + ~b + 1: b is inverted at accept and the +1 enters as the initial carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (accept) begin
            a_q       <= a;
            b_q       <= b ^ {WIDTH{sub}};
            carry_q   <= sub;
            cnt_q     <= '0;
            result_q  <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (cnt_q == CW'(i)) result_q[i*CHUNK +: CHUNK] <= sum;
            end
            carry_q <= cout;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                carry_out <= cout;
                overflow  <= c_msb ^ cout;
                zero      <= ((result_q & LOW_MASK) == '0) && (sum == '0);
                negative  <= sum[CHUNK-1];
            end
        end
    end

endmodule
